// File: rtl/sha256_core_iter.sv
`default_nettype none
// ============================================================================
// Module   : sha256_core_iter
// Purpose  : Iterative SHA-256 compression engine. Accepts one 512-bit block
//            plus a chaining value, runs the 64 compression rounds over
//            64/ROUNDS_PER_CYCLE clocks and returns the updated digest.
// Params   : ROUNDS_PER_CYCLE - rounds unrolled per clock (1, 2, 4 or 8)
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            start      - block request, accepted only while ready=1
//            init       - 1: start from the IV, 0: start from digest_in
//            sha224     - (SHA256_CORE_SHA224_EN only) select SHA-224 IV and
//                         truncate the last digest word to zero
//            digest_in  - chaining value, word A in [255:224]
//            message    - message block, W0 in [511:480]
//            ready      - engine idle
//            valid      - one-cycle pulse, digest_out freshly updated
//            digest_out - result, H0' in [255:224], held until next result
// Options  : define SHA256_CORE_SHA224_EN to add the SHA-224 mode
// Revision : 1.0 - initial release
// ============================================================================
module sha256_core_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         init,
`ifdef SHA256_CORE_SHA224_EN
    input  logic         sha224,
`endif
    input  logic [255:0] digest_in,
    input  logic [511:0] message,
    output logic         ready,
    output logic         valid,
    output logic [255:0] digest_out
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_rpc_check
            $error("sha256_core_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [255:0] c_iv256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA256_CORE_SHA224_EN
    localparam logic [255:0] c_iv224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ------------------------------------------------------------------
    // FIPS 180-4 helper functions
    // ------------------------------------------------------------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] round_f(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [6:0]    r_cnt;          // rounds completed so far, 0..64
    logic [6:0]    w_cnt_next;
    logic [255:0]  r_h;            // chaining value captured at start
    logic [255:0]  r_work;         // working variables a..h, a in [255:224]
    logic [31:0]   r_w [16];       // sliding schedule window, r_w[0] = W[t]
    logic          r_valid;
    logic [255:0]  r_digest;
`ifdef SHA256_CORE_SHA224_EN
    logic          r_sha224;
`endif

    logic [255:0]  w_chain;
    logic [255:0]  w_work_next;
    logic [31:0]   w_ext [16 + ROUNDS_PER_CYCLE];
    logic [255:0]  w_sum;

    assign w_cnt_next = r_cnt + 7'(ROUNDS_PER_CYCLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                if (w_cnt_next == 7'd64) begin
                    w_state_next = S_FINAL;
                end
            end
            S_FINAL: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
`ifdef SHA256_CORE_SHA224_EN
        w_chain = init ? (sha224 ? c_iv224 : c_iv256) : digest_in;
`else
        w_chain = init ? c_iv256 : digest_in;
`endif
    end

    // ROUNDS_PER_CYCLE rounds chained in one clock; round j of this cycle
    // uses schedule word r_w[j] and constant K[r_cnt + j].
    always_comb begin
        w_work_next = r_work;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_work_next = round_f(w_work_next, c_k[r_cnt[5:0] + 6'(j)], r_w[j]);
        end
    end

    // Extend the window by ROUNDS_PER_CYCLE words; later new words may depend
    // on earlier new words of the same cycle (W[t-2] term), hence the chain.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_w[i];
        end
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_ext[16 + j] = ssig1(w_ext[14 + j]) + w_ext[9 + j] +
                            ssig0(w_ext[1 + j]) + w_ext[j];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum[32*i +: 32] = r_h[32*i +: 32] + r_work[32*i +: 32];
        end
`ifdef SHA256_CORE_SHA224_EN
        if (r_sha224) begin
            w_sum[31:0] = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_h      <= '0;
            r_work   <= '0;
            r_valid  <= 1'b0;
            r_digest <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
`ifdef SHA256_CORE_SHA224_EN
            r_sha224 <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_h    <= w_chain;
                        r_work <= w_chain;
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= message[511 - 32*i -: 32];
                        end
`ifdef SHA256_CORE_SHA224_EN
                        r_sha224 <= sha224;
`endif
                    end
                end
                S_ROUND: begin
                    r_cnt  <= w_cnt_next;
                    r_work <= w_work_next;
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_ext[i + ROUNDS_PER_CYCLE];
                    end
                end
                S_FINAL: begin
                    r_digest <= w_sum;
                    r_valid  <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid      = r_valid;
    assign digest_out = r_digest;

endmodule
`default_nettype wire
